// File: rtl/card_shoe.sv
// ----------------------------------------------------------------------------
// card_shoe
// Responder end of the card-draw interface. Holds a 52-card deck, refills it
// in order, then shuffles it in place with Fisher-Yates. The random indices
// come from a 16-bit Galois LFSR, and out-of-range indices are rejected.
// Cards are served one per accepted draw request.
//
// Ports
//   i_clk            system clock
//   i_reset          asynchronous, active-high reset
//   i_drawRequest    draw request, accepted only while o_ready=1
//   i_reshuffle      refill and reshuffle (honoured in S_READY / S_EMPTY)
//   o_ready          idle, non-empty, able to accept a draw
//   o_cardValid      one-cycle pulse, o_cardRank/o_cardSuit valid
//   o_cardRank       1=Ace .. 10, 11=J, 12=Q, 13=K
//   o_cardSuit       0..3
//   o_cardsRemaining undealt cards, 0..52
//   o_deckEmpty      no cards left and no shuffle running
//   o_shuffling      refill or shuffle in progress
// ----------------------------------------------------------------------------
module card_shoe #(
   parameter logic [15:0] SEED           = 16'hACE1,
   parameter bit          AUTO_RESHUFFLE = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_drawRequest,
   input  logic       i_reshuffle,
   output logic       o_ready,
   output logic       o_cardValid,
   output logic [3:0] o_cardRank,
   output logic [1:0] o_cardSuit,
   output logic [5:0] o_cardsRemaining,
   output logic       o_deckEmpty,
   output logic       o_shuffling
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [15:0] TAPS     = 16'hB400;

   typedef enum logic [2:0] {
      S_INIT,
      S_SHUFFLE,
      S_READY,
      S_DELIVER,
      S_EMPTY
   } state_t;

   state_t      state;
   logic [15:0] lfsr;
   logic [15:0] lfsrNext;
   logic [5:0]  deck [52];      // {suit[1:0], rank[3:0]}
   logic [5:0]  initIdx;
   logic [3:0]  initRank;
   logic [1:0]  initSuit;
   logic [5:0]  shufIdx;        // Fisher-Yates i
   logic [5:0]  pointer;        // next card to deal
   logic [5:0]  swapJ;
   logic        swapTake;

   assign lfsrNext = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
   assign swapJ    = lfsr[5:0];
   assign swapTake = (swapJ <= shufIdx);

   // The LFSR free-runs in every state, so the shuffle outcome depends on
   // when the shuffle starts as well as on the seed.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         lfsr <= SEED_EFF;
      end else begin
         lfsr <= lfsrNext;
      end
   end

   // NOTE: the deck array has no reset. S_INIT rewrites every entry before
   // any entry is read, so a reset network on 52 words would buy nothing.
   always_ff @(posedge i_clk) begin
      if (state == S_INIT) begin
         deck[initIdx] <= {initSuit, initRank};
      end else if (state == S_SHUFFLE && swapTake) begin
         // NOTE: non-blocking assignments make both reads see the old
         // contents, so the two writes form a true swap. When j == i the
         // swap is a harmless self-write.
         deck[shufIdx] <= deck[swapJ];
         deck[swapJ]   <= deck[shufIdx];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state            <= S_INIT;
         initIdx          <= 6'd0;
         initRank         <= 4'd1;
         initSuit         <= 2'd0;
         shufIdx          <= 6'd51;
         pointer          <= 6'd0;
         o_ready          <= 1'b0;
         o_cardValid      <= 1'b0;
         o_cardRank       <= 4'd0;
         o_cardSuit       <= 2'd0;
         o_cardsRemaining <= 6'd0;
         o_deckEmpty      <= 1'b0;
         o_shuffling      <= 1'b1;
      end else begin
         o_cardValid <= 1'b0;
         case (state)
            S_INIT: begin
               // The rank/suit counters walk {k/13, k%13+1} without a divider.
               if (initRank == 4'd13) begin
                  initRank <= 4'd1;
                  initSuit <= initSuit + 2'd1;
               end else begin
                  initRank <= initRank + 4'd1;
               end
               if (initIdx == 6'd51) begin
                  // The counters wrap back to their start values here, so the
                  // next refill starts clean from any entry point.
                  initIdx <= 6'd0;
                  shufIdx <= 6'd51;
                  state   <= S_SHUFFLE;
               end else begin
                  initIdx <= initIdx + 6'd1;
               end
            end

            S_SHUFFLE: begin
               // Rejection sampling: an index j > i leaves i unchanged and
               // waits for the next LFSR value.
               if (swapTake) begin
                  if (shufIdx == 6'd1) begin
                     pointer          <= 6'd0;
                     o_cardsRemaining <= 6'd52;
                     o_ready          <= 1'b1;
                     o_shuffling      <= 1'b0;
                     state            <= S_READY;
                  end else begin
                     shufIdx <= shufIdx - 6'd1;
                  end
               end
            end

            S_READY: begin
               if (i_reshuffle) begin
                  o_ready          <= 1'b0;
                  o_shuffling      <= 1'b1;
                  o_cardsRemaining <= 6'd0;
                  state            <= S_INIT;
               end else if (i_drawRequest && o_ready) begin
                  o_ready                  <= 1'b0;
                  o_cardValid              <= 1'b1;
                  {o_cardSuit, o_cardRank} <= deck[pointer];
                  o_cardsRemaining         <= o_cardsRemaining - 6'd1;
                  // The pointer holds at 51 after the last card.
                  if (o_cardsRemaining != 6'd1) begin
                     pointer <= pointer + 6'd1;
                  end
                  state <= S_DELIVER;
               end
            end

            S_DELIVER: begin
               if (o_cardsRemaining != 6'd0) begin
                  o_ready <= 1'b1;
                  state   <= S_READY;
               end else if (AUTO_RESHUFFLE) begin
                  o_shuffling <= 1'b1;
                  state       <= S_INIT;
               end else begin
                  o_deckEmpty <= 1'b1;
                  state       <= S_EMPTY;
               end
            end

            S_EMPTY: begin
               if (i_reshuffle) begin
                  o_deckEmpty <= 1'b0;
                  o_shuffling <= 1'b1;
                  state       <= S_INIT;
               end
            end

            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_card_shoe.sv
// ----------------------------------------------------------------------------
// tb_card_shoe
// Scoreboard bench for card_shoe. Two instances share one clock. dut 0 has
// AUTO_RESHUFFLE=0 and dut 1 has AUTO_RESHUFFLE=1. Stimulus pushes the
// expected card for each accepted draw. A negedge monitor pops the expected
// card on every o_cardValid and checks four things: the dealt card, the
// remaining count, deck uniqueness and delivery spacing. The first deck
// after a reset is predicted by a bench-side LFSR / Fisher-Yates model.
// ----------------------------------------------------------------------------
module tb_card_shoe;

   typedef struct {
      logic [1:0] suit;
      logic [3:0] rank;
      logic [5:0] remaining;
      bit         checkCard;
      bit         checkGap;
      bit         newDeck;
   } sb_t;

   logic       clk;
   logic       rst     [2];
   logic       drawReq [2];
   logic       reshuf  [2];
   logic       ready   [2];
   logic       valid   [2];
   logic [3:0] rank    [2];
   logic [1:0] suit    [2];
   logic [5:0] rem     [2];
   logic       empty   [2];
   logic       shuf    [2];

   int         compared   = 0;
   int         mismatched = 0;
   int         cycle      = 0;
   int         lastValid  [2];
   logic [63:0] seen      [2];
   logic [5:0] expDeck    [52];
   int         expRem     [2];
   int         expIdx     [2];
   sb_t        q0 [$];
   sb_t        q1 [$];

   card_shoe #(.SEED(16'hACE1), .AUTO_RESHUFFLE(1'b0)) dut0 (
      .i_clk(clk), .i_reset(rst[0]), .i_drawRequest(drawReq[0]),
      .i_reshuffle(reshuf[0]), .o_ready(ready[0]), .o_cardValid(valid[0]),
      .o_cardRank(rank[0]), .o_cardSuit(suit[0]), .o_cardsRemaining(rem[0]),
      .o_deckEmpty(empty[0]), .o_shuffling(shuf[0])
   );

   card_shoe #(.SEED(16'hACE1), .AUTO_RESHUFFLE(1'b1)) dut1 (
      .i_clk(clk), .i_reset(rst[1]), .i_drawRequest(drawReq[1]),
      .i_reshuffle(reshuf[1]), .o_ready(ready[1]), .o_cardValid(valid[1]),
      .o_cardRank(rank[1]), .o_cardSuit(suit[1]), .o_cardsRemaining(rem[1]),
      .o_deckEmpty(empty[1]), .o_shuffling(shuf[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic logic [15:0] lfsrStep(input logic [15:0] x);
      return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
   endfunction

   // Expected first deck after reset: 52 refill cycles advance the LFSR,
   // then each shuffle cycle uses the current LFSR[5:0] as j.
   task automatic buildModel();
      logic [15:0] l;
      logic [5:0]  tmp;
      int          i;
      int          j;
      int          guard;
      l = 16'hACE1;
      for (int k = 0; k < 52; k++) expDeck[k] = {2'(k / 13), 4'(k % 13 + 1)};
      repeat (52) l = lfsrStep(l);
      i = 51;
      guard = 0;
      while (i >= 1 && guard < 100000) begin
         j = int'(l[5:0]);
         if (j <= i) begin
            tmp        = expDeck[i];
            expDeck[i] = expDeck[j];
            expDeck[j] = tmp;
            i--;
         end
         l = lfsrStep(l);
         guard++;
      end
   endtask

   task automatic pushSb(input int d, input sb_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Monitor: every delivery must match the oldest expectation.
   always @(negedge clk) begin
      sb_t  e;
      logic fresh;
      cycle++;
      for (int d = 0; d < 2; d++) begin
         if (valid[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               check($sformatf("unexpected_card_dut%0d", d), 32'(valid[d]), 32'd0);
            end else begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               check($sformatf("remaining_dut%0d", d), 32'(rem[d]), 32'(e.remaining));
               if (e.checkCard)
                  check($sformatf("card_dut%0d", d), 32'({suit[d], rank[d]}), 32'({e.suit, e.rank}));
               if (e.newDeck) seen[d] = '0;
               fresh = (rank[d] >= 4'd1) && (rank[d] <= 4'd13) && !seen[d][{suit[d], rank[d]}];
               check($sformatf("card_unique_dut%0d", d), 32'(fresh), 32'd1);
               seen[d][{suit[d], rank[d]}] = 1'b1;
               if (e.checkGap)
                  check($sformatf("valid_spacing_dut%0d", d), 32'(cycle - lastValid[d]), 32'd2);
               lastValid[d] = cycle;
            end
         end
      end
   end

   task automatic waitReady(input int d, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (ready[d]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // One draw: request at a negedge with o_ready high; the card shows one cycle later.
   task automatic draw(input int d, input bit checkCard, input bit checkGap, input bit newDeck);
      bit  ok;
      sb_t e;
      waitReady(d, 4, ok);
      check($sformatf("draw_ready_dut%0d", d), 32'(ok), 32'd1);
      if (!ok) return;
      expRem[d]--;
      e.suit      = expDeck[expIdx[d]][5:4];
      e.rank      = expDeck[expIdx[d]][3:0];
      e.remaining = 6'(expRem[d]);
      e.checkCard = checkCard;
      e.checkGap  = checkGap;
      e.newDeck   = newDeck;
      if (expIdx[d] < 51) expIdx[d]++;
      pushSb(d, e);
      drawReq[d] = 1'b1;
      @(negedge clk);
      drawReq[d] = 1'b0;
   endtask

   task automatic checkResetValues(input int d, input string tag);
      check({tag, "_ready"},     32'(ready[d]), 32'd0);
      check({tag, "_valid"},     32'(valid[d]), 32'd0);
      check({tag, "_rank"},      32'(rank[d]),  32'd0);
      check({tag, "_suit"},      32'(suit[d]),  32'd0);
      check({tag, "_remaining"}, 32'(rem[d]),   32'd0);
      check({tag, "_deckEmpty"}, 32'(empty[d]), 32'd0);
      check({tag, "_shuffling"}, 32'(shuf[d]),  32'd1);
   endtask

   task automatic waitShuffleDone(input int d, input string tag);
      bit ok;
      waitReady(d, 2100, ok);
      check({tag, "_ready_timeout"}, 32'(ok), 32'd1);
      check({tag, "_remaining52"}, 32'(rem[d]), 32'd52);
      check({tag, "_not_shuffling"}, 32'(shuf[d]), 32'd0);
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: run exceeded 60000 cycles");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      bit  ok;
      sb_t e;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; drawReq[d] = 1'b0; reshuf[d] = 1'b0;
         seen[d] = '0; lastValid[d] = 0; expRem[d] = 0; expIdx[d] = 0;
      end
      buildModel();

      // Reset state, refill length, first shuffle.
      repeat (2) @(negedge clk);
      checkResetValues(0, "reset0");
      checkResetValues(1, "reset1");
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      cnt = 0;
      for (int c = 0; c < 52; c++) begin
         @(negedge clk);
         if (shuf[0] && !ready[0]) cnt++;
      end
      check("init_shuffling_52", 32'(cnt), 32'd52);
      waitShuffleDone(0, "first0");
      waitShuffleDone(1, "first1");

      // 52 back-to-back draws on dut0, matching the model deck.
      expRem[0] = 52; expIdx[0] = 0;
      for (int k = 0; k < 52; k++) draw(0, 1'b1, k > 0, k == 0);
      @(negedge clk);
      check("empty_after_52", 32'(empty[0]), 32'd1);
      check("ready_after_52", 32'(ready[0]), 32'd0);

      // Draws are ignored while empty; a reshuffle refills the deck.
      drawReq[0] = 1'b1;
      repeat (10) @(negedge clk);
      drawReq[0] = 1'b0;
      check("empty_held", 32'(empty[0]), 32'd1);
      check("remaining_zero", 32'(rem[0]), 32'd0);
      reshuf[0] = 1'b1;
      @(negedge clk);
      reshuf[0] = 1'b0;
      check("reshuffle_starts", 32'(shuf[0]), 32'd1);
      check("reshuffle_clears_empty", 32'(empty[0]), 32'd0);
      waitShuffleDone(0, "manual_reshuffle");
      expRem[0] = 52;
      for (int k = 0; k < 12; k++) draw(0, 1'b0, k > 0, k == 0);

      // Reshuffle and draw in the same cycle with 40 left: reshuffle wins.
      waitReady(0, 4, ok);
      check("rem40_ready", 32'(ok), 32'd1);
      check("rem40", 32'(rem[0]), 32'd40);
      drawReq[0] = 1'b1;
      reshuf[0]  = 1'b1;
      @(negedge clk);
      drawReq[0] = 1'b0;
      reshuf[0]  = 1'b0;
      check("collide_shuffling", 32'(shuf[0]), 32'd1);
      check("collide_ready", 32'(ready[0]), 32'd0);
      waitShuffleDone(0, "collide");

      // Reset in the cycle after an accept: the card is lost.
      waitReady(0, 4, ok);
      check("pre_reset_ready", 32'(ok), 32'd1);
      drawReq[0] = 1'b1;
      @(posedge clk);
      #1;
      rst[0]     = 1'b1;
      drawReq[0] = 1'b0;
      @(negedge clk);
      checkResetValues(0, "midreset");
      @(negedge clk);
      rst[0] = 1'b0;
      waitShuffleDone(0, "after_reset");
      // The same seed after reset must reproduce the model deck.
      expRem[0] = 52; expIdx[0] = 0;
      for (int k = 0; k < 6; k++) draw(0, 1'b1, k > 0, k == 0);

      // AUTO_RESHUFFLE=1: deal all of dut1, then hold a request through the shuffle.
      expRem[1] = 52; expIdx[1] = 0;
      for (int k = 0; k < 52; k++) draw(1, 1'b1, k > 0, k == 0);
      drawReq[1] = 1'b1;
      @(negedge clk);
      check("auto_shuffling_next", 32'(shuf[1]), 32'd1);
      check("auto_not_empty", 32'(empty[1]), 32'd0);
      check("auto_not_ready", 32'(ready[1]), 32'd0);
      waitReady(1, 2100, ok);
      check("auto_ready_timeout", 32'(ok), 32'd1);
      check("auto_remaining52", 32'(rem[1]), 32'd52);
      if (ok) begin
         e.suit = 2'd0; e.rank = 4'd0; e.remaining = 6'd51;
         e.checkCard = 1'b0; e.checkGap = 1'b0; e.newDeck = 1'b1;
         pushSb(1, e);
      end
      @(negedge clk);
      drawReq[1] = 1'b0;

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Responder end of the card-draw interface used by the game FSM.
- Holds a 52-card deck in a register array and shuffles it in hardware (Fisher-Yates driven by an LFSR).
- Serves one card per accepted draw request, with a valid pulse and a remaining-count readout.
- Reshuffles on command or automatically when empty, so a round never sees a repeated card between shuffles.

Parameters:
- SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'h0001.
- AUTO_RESHUFFLE, 1, 1 = start a shuffle automatically when the last card is delivered; 0 = stay empty until i_reshuffle.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_drawRequest  input  1  draw request; accepted only in a cycle where o_ready=1
- i_reshuffle  input  1  request a full reshuffle (refills the deck)
- o_ready  output  1  deck idle, non-empty, able to accept a draw
- o_cardValid  output  1  one-cycle pulse; o_cardRank/o_cardSuit are valid this cycle
- o_cardRank  output  4  1=Ace .. 10, 11=J, 12=Q, 13=K
- o_cardSuit  output  2  0..3
- o_cardsRemaining  output  6  undealt cards, 0..52
- o_deckEmpty  output  1  high when o_cardsRemaining==0 and no shuffle is running
- o_shuffling  output  1  high during S_INIT and S_SHUFFLE

Behaviour:
- Reset values: o_ready=0, o_cardValid=0, o_cardRank=0, o_cardSuit=0, o_cardsRemaining=0, o_deckEmpty=0, o_shuffling=1. State=S_INIT, LFSR=SEED (or 1), draw pointer=0.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every clock in every state except during reset.
  - Never reaches 0.
- Deck storage: 52 entries of {suit[1:0], rank[3:0]}.
- S_INIT:
  - Writes entry k = {k/13, k%13+1} for k=0..51, one entry per cycle (52 cycles), using rank/suit counters, not division.
  - Then goes to S_SHUFFLE with i=51.
- S_SHUFFLE:
  - Each cycle takes j = LFSR[5:0].
  - If j<=i: swap entries i and j in the same cycle, then decrement i.
  - If j>i: reject; no swap, i unchanged.
  - When i would go below 1: pointer=0, o_cardsRemaining=52, go to S_READY.
  - Completion is guaranteed only probabilistically; the bench bound is 2000 cycles.
- S_READY:
  - o_ready = (o_cardsRemaining != 0).
  - i_reshuffle=1 goes to S_INIT (full refill, then shuffle), o_ready=0 next cycle. It takes priority over a simultaneous i_drawRequest, which is dropped.
  - i_drawRequest=1 with o_ready=1 (accept in cycle N) goes to S_DELIVER.
  - i_drawRequest while o_ready=0 (any state) is ignored and not queued.
- S_DELIVER (cycle N+1):
  - o_cardValid=1; o_cardRank/o_cardSuit = entry[pointer].
  - pointer += 1; o_cardsRemaining decrements, visible in the same cycle as the valid pulse.
  - o_ready=0.
  - Next state:
    - S_READY if cards remain;
    - else S_INIT if AUTO_RESHUFFLE=1;
    - else S_EMPTY.
- The earliest next accept is cycle N+2, so at most one card every 2 cycles.
- o_cardRank/o_cardSuit hold the last delivered card until the next delivery. They are only meaningful when o_cardValid=1.
- S_EMPTY:
  - o_deckEmpty=1, o_ready=0; draws ignored.
  - i_reshuffle goes to S_INIT.
- i_reshuffle during S_INIT/S_SHUFFLE/S_DELIVER is ignored. A shuffle is already pending or finishing; the delivery completes normally.
- Reset asserted in any state (including mid-swap or mid-delivery) returns to the reset values immediately. Any pending card is lost and no o_cardValid is produced.
- o_cardsRemaining never underflows or exceeds 52. The pointer never indexes past 51.

Test Plan:
- Reset with SEED=16'hACE1 -> o_shuffling=1 for 52 INIT cycles plus the shuffle. o_ready rises within 2000 cycles with o_cardsRemaining=52. Two runs with the same seed produce identical card sequences.
- 52 back-to-back draws (request on every o_ready) -> 52 o_cardValid pulses spaced exactly 2 cycles apart. Every {suit,rank} pair appears exactly once. o_cardsRemaining counts 51..0.
- AUTO_RESHUFFLE=0, draw all 52, then assert i_drawRequest for 10 cycles -> no o_cardValid, o_deckEmpty=1. Then i_reshuffle -> o_shuffling=1, later o_ready=1 with o_cardsRemaining=52.
- AUTO_RESHUFFLE=1, 52nd delivery -> o_shuffling rises the next cycle; a request held high during the shuffle yields no card until o_ready returns.
- Same-cycle i_reshuffle and i_drawRequest in S_READY with 40 remaining -> no o_cardValid; S_INIT entered; after the shuffle o_cardsRemaining=52.
- Assert i_reset in the cycle after a draw is accepted -> no o_cardValid pulse; all outputs at reset values; normal operation resumes after release.
